rr_gnt_arb: RTL
===============

# rr_gnt_arb

Round-robin grant arbiter for the pSLIP output-port request/grant/accept handshake. Consumes the masked request vector produced by the per-output priority selector (all requests sharing the highest priority), picks one input by iSLIP round-robin from a grant pointer, and holds the grant until the accept stage responds. The pointer advances only when the grant is accepted. A done pulse restarts the upstream priority selector for the next round.

## Interface
- N, 16, number of input ports; power of two, ≥2
- W, $clog2(N), index width (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req  in  N  request vector, bit i = input i requests this output; sampled only with req_valid
- req_valid  in  1  one-cycle pulse from the priority selector's ready
- gnt  out  N  one-hot grant; zero when gnt_valid=0
- gnt_idx  out  W  binary index of granted input; 0 when gnt_valid=0
- gnt_valid  out  1  grant presented to the accept stage
- acc_valid  in  1  accept stage response strobe, meaningful only while gnt_valid=1
- accept  in  1  with acc_valid: 1 = grant accepted, 0 = declined
- done  out  1  one-cycle pulse: round finished, upstream may issue the next update
- overrun  out  1  one-cycle pulse: req_valid arrived while not IDLE (request dropped)
- ptr  out  W  current grant pointer, for debug/scoreboard

## Operation
- State machine of IDLE, ARB, WAIT_ACC
- IDLE: on req_valid with req≠0 -> capture req into req_q, go ARB. On req_valid with req=0 -> stay IDLE, pulse done next cycle, no grant.
- ARB: rr_pick selects the first set bit of req_q scanning ptr, ptr+1, …, N-1, 0, …, ptr-1. Register gnt (one-hot), gnt_idx, gnt_valid=1; go WAIT_ACC. Always one cycle.
- WAIT_ACC: hold gnt, gnt_idx, gnt_valid stable until acc_valid=1. Then:
  - accept=1: ptr <= (gnt_idx+1) mod N (natural W-bit wrap); N-1 wraps to 0
  - accept=0: ptr unchanged
  - either case: clear gnt/gnt_idx/gnt_valid, pulse done, go IDLE
- acc_valid outside WAIT_ACC: ignored
- req_valid in ARB or WAIT_ACC: request dropped, req_q unchanged, overrun pulses next cycle
- Single-request req: granted regardless of ptr
- req_q bits never change between capture and return to IDLE

## Timing
- Reset values: state=IDLE, ptr=0, req_q=0, gnt=0, gnt_idx=0, gnt_valid=0, done=0, overrun=0
- Reset overrides everything, including mid-WAIT_ACC: grant dropped, ptr returns to 0, no done pulse
- req_valid at edge t (IDLE) -> ARB in t+1 -> gnt_valid=1 from t+2
- acc_valid at edge t (WAIT_ACC) -> gnt_valid=0, done=1, ptr updated, state IDLE from t+1; done low again at t+2
- Zero request: req_valid at t -> done=1 during t+1 only
- Earliest next capture: req_valid in the same cycle done is high (state already IDLE)
- All outputs registered; no combinational input-to-output paths

## Structure
- Shared package pslip_pkg: typedef enum logic [1:0] arb_state_t {IDLE, ARB, WAIT_ACC}; default port count constant shared with the priority selector
- Sub-module rr_pick (combinational, parameter N): inputs req_q and ptr, outputs one-hot pick and binary index; implemented as double-width vector masked by the pointer with a fallback unmasked priority encode
- Top holds the FSM, req_q, ptr and output registers

## Test plan
- Reset then req=16'h0000 with req_valid -> no gnt_valid, done pulses exactly one cycle later, ptr=0
- ptr=0, req=16'h0090 -> gnt=16'h0010, gnt_idx=4 at t+2; accept=1 -> ptr=5, next identical req grants idx 7
- ptr=15 after accepting idx 14, req=16'h8001 -> grants idx 15; accept=1 -> ptr wraps to 0; repeat -> grants idx 0
- req=16'h0404 granted idx 2, accept=0 -> ptr stays 0, done pulses; resubmit -> idx 2 again
- req_valid pulsed during WAIT_ACC with req=16'hFFFF -> overrun pulses once, gnt and gnt_idx unchanged, req_q unchanged
- reset asserted while gnt_valid=1 at ptr=9 -> next cycle gnt_valid=0, ptr=0, done=0; fresh req=16'h0200 grants idx 9

Source files
------------

// File: rtl/pslip_pkg.sv
// Shared pSLIP definitions: arbiter FSM encoding and the default port count
// used by both the priority selector and the round-robin grant arbiter.
package pslip_pkg;

  localparam int PSLIP_N = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARB      = 2'd1,
    WAIT_ACC = 2'd2
  } arb_state_t;

endpackage : pslip_pkg

// File: rtl/rr_gnt_arb_if.sv
// Request/grant/accept bundle between the priority selector, the grant
// arbiter (slave) and the accept stage (master side drives requests/accepts).
interface rr_gnt_arb_if
  import pslip_pkg::*;
#(
  parameter int N = PSLIP_N
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         req_valid;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;
  logic         acc_valid;
  logic         accept;
  logic         done;
  logic         overrun;
  logic [W-1:0] ptr;

  modport master (
    output req, req_valid, acc_valid, accept,
    input  gnt, gnt_idx, gnt_valid, done, overrun, ptr
  );

  modport slave (
    input  req, req_valid, acc_valid, accept,
    output gnt, gnt_idx, gnt_valid, done, overrun, ptr
  );

endinterface : rr_gnt_arb_if

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of i_req scanning from
// i_ptr upward with wrap-around.
module rr_pick #(
  parameter int N = 16
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_pick,
  output logic [$clog2(N)-1:0] o_idx
);
  localparam int W = $clog2(N);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]   w_mask;
  logic [2*N-1:0] w_dbl;
  logic [W-1:0]   w_pos;

  // Low half keeps only bits at or above the pointer; the unmasked high half
  // is the fallback when nothing at or above the pointer is requesting.
  assign w_mask = ~((ONE << i_ptr) - ONE);
  assign w_dbl  = {i_req, i_req & w_mask};

  // Lowest set bit of the double-width vector; its low W bits fold it to an index.
  always_comb begin
    w_pos = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        w_pos = W'(i);
      end else begin
        w_pos = w_pos;
      end
    end
  end

  assign o_idx  = w_pos;
  assign o_pick = (|i_req) ? (ONE << w_pos) : {N{1'b0}};

endmodule : rr_pick

// File: rtl/rr_gnt_arb.sv
// pSLIP output-port grant arbiter: captures a masked request vector, grants
// one input round-robin, holds it until the accept stage answers.
module rr_gnt_arb
  import pslip_pkg::*;
#(
  parameter int N = PSLIP_N
) (
  input  logic         clk,
  input  logic         reset,
  rr_gnt_arb_if.slave  bus
);
  localparam int W = $clog2(N);

  arb_state_t   r_state;
  logic [N-1:0] r_req_q;
  logic [W-1:0] r_ptr;
  logic [N-1:0] r_gnt;
  logic [W-1:0] r_gnt_idx;
  logic         r_gnt_valid;
  logic         r_done;
  logic         r_overrun;

  logic [N-1:0] w_pick;
  logic [W-1:0] w_idx;

  rr_pick #(.N(N)) u_pick (
    .i_req  (r_req_q),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_idx)
  );

  // FSM, captured request, grant pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_q     <= {N{1'b0}};
      r_ptr       <= {W{1'b0}};
      r_gnt       <= {N{1'b0}};
      r_gnt_idx   <= {W{1'b0}};
      r_gnt_valid <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            if (|bus.req) begin
              r_req_q <= bus.req;
              r_state <= ARB;
            end else begin
              r_done  <= 1'b1;
            end
          end
        end
        ARB: begin
          r_gnt       <= w_pick;
          r_gnt_idx   <= w_idx;
          r_gnt_valid <= 1'b1;
          r_overrun   <= bus.req_valid;
          r_state     <= WAIT_ACC;
        end
        WAIT_ACC: begin
          r_overrun <= bus.req_valid;
          if (bus.acc_valid) begin
            // N is a power of two, so the W-bit add wraps N-1 back to 0.
            if (bus.accept) begin
              r_ptr <= r_gnt_idx + W'(1);
            end
            r_gnt       <= {N{1'b0}};
            r_gnt_idx   <= {W{1'b0}};
            r_gnt_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_gnt       <= {N{1'b0}};
          r_gnt_idx   <= {W{1'b0}};
          r_gnt_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.done      = r_done;
  assign bus.overrun   = r_overrun;
  assign bus.ptr       = r_ptr;

endmodule : rr_gnt_arb
